// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Direct-mapped BTB with 2-bit direction counters and a saturating
//            misprediction statistics counter.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int PC_WIDTH  = 32,
    parameter int IDX_BITS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PC_WIDTH-1:0]  IF_PC,
    output logic                 Predict_Taken,
    output logic [PC_WIDTH-1:0]  Predict_Target,
    input  logic                 Upd_en,
    input  logic [PC_WIDTH-1:0]  Upd_PC,
    input  logic                 Upd_Taken,
    input  logic                 Upd_Jump,
    input  logic [PC_WIDTH-1:0]  Upd_Target,
    input  logic                 Upd_Mispredict,
    output logic [CNT_WIDTH-1:0] Mispredict_Cnt
);

    localparam int         c_DEPTH = 1 << IDX_BITS;
    localparam int         c_TAG_W = PC_WIDTH - IDX_BITS - 2;
    localparam logic [1:0] c_SNT   = 2'b00;
    localparam logic [1:0] c_WNT   = 2'b01;
    localparam logic [1:0] c_WT    = 2'b10;
    localparam logic [1:0] c_ST    = 2'b11;

    logic                 r_valid  [c_DEPTH];
    logic [c_TAG_W-1:0]   r_tag    [c_DEPTH];
    logic [PC_WIDTH-1:0]  r_target [c_DEPTH];
    logic [1:0]           r_ctr    [c_DEPTH];
    logic [CNT_WIDTH-1:0] r_mcnt;

    logic [IDX_BITS-1:0]  w_if_idx;
    logic [c_TAG_W-1:0]   w_if_tag;
    logic                 w_if_hit;
    logic [IDX_BITS-1:0]  w_upd_idx;
    logic [c_TAG_W-1:0]   w_upd_tag;
    logic                 w_upd_hit;
    logic                 w_wr_en;
    logic                 w_load_tgt;
    logic [1:0]           w_nxt_ctr;
    logic                 w_unused_pc_bits;

    // Byte offset within the word never participates in index or tag.
    assign w_unused_pc_bits = &{1'b0, IF_PC[1:0], Upd_PC[1:0]};

    // Lookup reads only registered state, so a same-cycle update is not seen.
    assign w_if_idx       = IF_PC[IDX_BITS+1:2];
    assign w_if_tag       = IF_PC[PC_WIDTH-1:IDX_BITS+2];
    assign w_if_hit       = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign Predict_Taken  = w_if_hit && r_ctr[w_if_idx][1];
    assign Predict_Target = Predict_Taken ? r_target[w_if_idx]
                                          : IF_PC + PC_WIDTH'(4);

    assign w_upd_idx = Upd_PC[IDX_BITS+1:2];
    assign w_upd_tag = Upd_PC[PC_WIDTH-1:IDX_BITS+2];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    always_comb begin
        w_wr_en    = 1'b0;
        w_load_tgt = 1'b0;
        w_nxt_ctr  = r_ctr[w_upd_idx];
        if (Upd_en) begin
            if (!w_upd_hit) begin
                // Only taken transfers allocate; an alias is simply replaced.
                if (Upd_Taken) begin
                    w_wr_en    = 1'b1;
                    w_load_tgt = 1'b1;
                    w_nxt_ctr  = Upd_Jump ? c_ST : c_WT;
                end
            end else begin
                w_wr_en = 1'b1;
                if (Upd_Jump) begin
                    w_load_tgt = 1'b1;
                    w_nxt_ctr  = c_ST;
                end else if (Upd_Taken) begin
                    w_load_tgt = 1'b1;
                    w_nxt_ctr  = (r_ctr[w_upd_idx] == c_ST) ? c_ST
                                                            : r_ctr[w_upd_idx] + 2'd1;
                end else begin
                    w_nxt_ctr  = (r_ctr[w_upd_idx] == c_SNT) ? c_SNT
                                                             : r_ctr[w_upd_idx] - 2'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= c_WNT;
            end
            r_mcnt <= '0;
        end else begin
            if (w_wr_en) begin
                r_valid[w_upd_idx] <= 1'b1;
                r_tag[w_upd_idx]   <= w_upd_tag;
                r_ctr[w_upd_idx]   <= w_nxt_ctr;
                if (w_load_tgt) begin
                    r_target[w_upd_idx] <= Upd_Target;
                end
            end
            if (Upd_en && Upd_Mispredict && (r_mcnt != {CNT_WIDTH{1'b1}})) begin
                r_mcnt <= r_mcnt + CNT_WIDTH'(1);
            end
        end
    end

    assign Mispredict_Cnt = r_mcnt;

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter PC_WIDTH, 32, width of all PC and target buses.
REQ-002 Parameter IDX_BITS, 4, index width; table depth = 2^IDX_BITS entries.
REQ-003 Parameter CNT_WIDTH, 16, width of the misprediction statistics counter.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 IF_PC  input  PC_WIDTH  fetch-stage PC being looked up.
REQ-007 Predict_Taken  output  1  IF-stage taken prediction for IF_PC.
REQ-008 Predict_Target  output  PC_WIDTH  predicted next PC when Predict_Taken=1, else IF_PC+4.
REQ-009 Upd_en  input  1  EX-stage resolved control-transfer update strobe, one cycle per instruction.
REQ-010 Upd_PC  input  PC_WIDTH  PC of the resolved branch or jump.
REQ-011 Upd_Taken  input  1  resolved direction (Branch_Taken or jump).
REQ-012 Upd_Jump  input  1  resolved instruction is JAL/JALR.
REQ-013 Upd_Target  input  PC_WIDTH  resolved target address.
REQ-014 Upd_Mispredict  input  1  EX detected prediction mismatch (direction or target).
REQ-015 Mispredict_Cnt  output  CNT_WIDTH  registered count of Upd_en cycles with Upd_Mispredict=1.

Function
REQ-016 Index = PC[IDX_BITS+1:2]; tag = PC[PC_WIDTH-1:IDX_BITS+2]; PC[1:0] ignored.
REQ-017 Each entry holds valid (1b), tag, target (PC_WIDTH), 2-bit counter: 00 SNT, 01 WNT, 10 WT, 11 ST.
REQ-018 Lookup purely combinational: hit = valid && tag match; Predict_Taken = hit && counter[1]; Predict_Target = stored target on Predict_Taken, else IF_PC+4 (modulo 2^PC_WIDTH).
REQ-019 Upd_en=1, miss, Upd_Taken=1: allocate entry (overwrite any alias) -- valid=1, tag, target=Upd_Target, counter=WT (ST if Upd_Jump).
REQ-020 Upd_en=1, miss, Upd_Taken=0: no state change.
REQ-021 Upd_en=1, hit, Upd_Jump=1: counter=ST, target=Upd_Target.
REQ-022 Upd_en=1, hit, branch taken: counter saturating increment (ST stays ST), target=Upd_Target.
REQ-023 Upd_en=1, hit, branch not taken: counter saturating decrement (SNT stays SNT), target unchanged, entry stays valid.
REQ-024 Upd_en=0: table unchanged; all Upd_* other inputs ignored.
REQ-025 Update takes effect on the next rising edge; lookup in the same cycle as an update to the same index returns the pre-update entry (no bypass).
REQ-026 Mispredict_Cnt increments by 1 on edges where Upd_en && Upd_Mispredict; saturates at all-ones.
REQ-027 Upd_Mispredict with Upd_en=0 ignored.

Reset
REQ-028 rst_n=0 at a rising edge: all valid bits 0, all counters WNT, targets and tags 0, Mispredict_Cnt 0.
REQ-029 Reset overrides a concurrent Upd_en on the same edge; no update applied.
REQ-030 While valid=0 everywhere, Predict_Taken=0 and Predict_Target=IF_PC+4 for any IF_PC.

Verification
REQ-031 Reset, IF_PC=0x100 -> Predict_Taken=0, Predict_Target=0x104, Mispredict_Cnt=0.
REQ-032 Upd_en, Upd_PC=0x100, Taken=1, Target=0x80, Mispredict=1; next cycle IF_PC=0x100 -> Predict_Taken=1, Target=0x80, Mispredict_Cnt=1.
REQ-033 From REQ-032 state: two not-taken updates at 0x100 -> after first Predict_Taken=0 (WNT), after second counter SNT; one taken update -> still Predict_Taken=0 (WNT).
REQ-034 Alias: entry 0x100 valid; taken update at 0x140, Target=0x200 -> IF_PC=0x100 Predict_Taken=0, IF_PC=0x140 Predict_Taken=1 Target=0x200.
REQ-035 Jump update Upd_PC=0x20, Jump=1, Target=0x400, with rst_n=0 same edge -> next cycle IF_PC=0x20 Predict_Taken=0, Predict_Target=0x24.
REQ-036 CNT_WIDTH=2: four mispredict updates -> Mispredict_Cnt sequence 1,2,3,3.
